// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the register-file write arbiter
package rf_arb_pkg;
    localparam int XLEN = 32;
    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ll_wb_t;
endpackage

// File: rtl/rf_arb_fifo.sv
// rtl/rf_arb_fifo.sv - DEPTH-entry FIFO of deferred long-latency writeback results
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  ll_wb_t                 pushData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output ll_wb_t                 head
);
    localparam int PW = $clog2(DEPTH);

    ll_wb_t         mem [DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic [PW:0]    countQ;
    logic           doPush;
    logic           doPop;

    assign full   = (countQ == (PW+1)'(DEPTH));
    assign empty  = (countQ == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign count  = countQ;
    assign head   = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
        end
    end

    // Storage needs no reset; the occupancy count defines which entries are live.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - single RF write port arbiter between WB and long-latency results
// Optional direct LL-to-RF path when the FIFO is empty: WB_BYPASS_EN
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_regwrite,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_result,
    input  logic                   ll_issue_valid,
    input  logic [4:0]             ll_issue_rd,
    input  logic                   ll_valid,
    output logic                   ll_ready,
    input  logic [4:0]             ll_rd,
    input  logic [XLEN-1:0]        ll_result,
    output logic                   rf_we,
    output logic [4:0]             rf_rd,
    output logic [XLEN-1:0]        rf_wd,
    output logic                   stall_wb,
    output logic [31:0]            pending_busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(MAX_WAIT + 1);
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ll_wb_t         head;
    ll_wb_t         pushData;
    logic           full;
    logic           empty;
    logic           slotBusy;
    logic           bypassSel;
    logic           popSel;
    logic           enqueue;
    logic           weSel;
    logic [AW-1:0]  age;
    logic [31:0]    setMask;
    logic [31:0]    clrMask;

    assign slotBusy  = wb_regwrite && (wb_rd != REG_X0);
    assign stall_wb  = (age >= AW'(MAX_WAIT)) && !empty;
    assign ll_ready  = !full;
    assign bypassSel = BYPASS && empty && !slotBusy && !stall_wb && ll_valid && (ll_rd != REG_X0);
    assign enqueue   = ll_valid && ll_ready && (ll_rd != REG_X0) && !bypassSel;
    assign popSel    = !empty && (stall_wb || !slotBusy);
    assign pushData  = '{rd: ll_rd, data: ll_result};
    // The write enable is held low while reset is asserted, even if WB keeps presenting.
    assign rf_we     = weSel && !reset;

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (enqueue),
        .pop      (popSel),
        .pushData (pushData),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count),
        .head     (head)
    );

    always_comb begin
        weSel = 1'b0;
        rf_rd = REG_X0;
        rf_wd = '0;
        if (stall_wb) begin
            weSel = 1'b1;
            rf_rd = head.rd;
            rf_wd = head.data;
        end else if (slotBusy) begin
            weSel = 1'b1;
            rf_rd = wb_rd;
            rf_wd = wb_result;
        end else if (!empty) begin
            weSel = 1'b1;
            rf_rd = head.rd;
            rf_wd = head.data;
        end else if (bypassSel) begin
            weSel = 1'b1;
            rf_rd = ll_rd;
            rf_wd = ll_result;
        end
    end

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (ll_issue_valid && (ll_issue_rd != REG_X0)) setMask[ll_issue_rd] = 1'b1;
        if (popSel || bypassSel) clrMask[rf_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age          <= '0;
            pending_busy <= '0;
        end else begin
            if (empty || popSel) age <= '0;
            else if (age < AW'(MAX_WAIT)) age <= age + 1'b1;
            // Set is applied after clear so a re-issue to the same register wins.
            pending_busy <= ((pending_busy & ~clrMask) | setMask) & ~32'd1;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
    localparam int CW       = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wb_regwrite = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_result = '0;
    logic            ll_issue_valid = 1'b0;
    logic [4:0]      ll_issue_rd = '0;
    logic            ll_valid = 1'b0;
    logic            ll_ready;
    logic [4:0]      ll_rd = '0;
    logic [XLEN-1:0] ll_result = '0;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic            stall_wb;
    logic [31:0]     pending_busy;
    logic [CW-1:0]   fifo_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ll_issue_valid(ll_issue_valid), .ll_issue_rd(ll_issue_rd),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_result(ll_result),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .stall_wb(stall_wb),
        .pending_busy(pending_busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic iv, input logic [4:0] ird,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] lres);
        wb_regwrite = we; wb_rd = rd; wb_result = res;
        ll_issue_valid = iv; ll_issue_rd = ird;
        ll_valid = lv; ll_rd = lrd; ll_result = lres;
    endtask

    task automatic doReset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Reference model: queue of deferred results, wait age, pending set.
    ll_wb_t      mq[$];
    int          mAge;
    logic [31:0] mBusy;
    logic        eWe, eStall, eReady, mPop, mEnq, mByp;
    logic [4:0]  eRd;
    logic [31:0] eWd;

    task automatic modelEval();
        logic mEmpty, slot;
        mEmpty = (mq.size() == 0);
        slot   = wb_regwrite && (wb_rd != 0);
        eReady = (mq.size() < DEPTH);
        eStall = !mEmpty && (mAge >= MAX_WAIT);
        mByp   = BYP && mEmpty && !slot && ll_valid && (ll_rd != 0);
        mPop = 0; eWe = 0; eRd = 0; eWd = 0;
        if (eStall || (!slot && !mEmpty)) begin
            eWe = 1; eRd = mq[0].rd; eWd = mq[0].data; mPop = 1;
        end else if (slot) begin
            eWe = 1; eRd = wb_rd; eWd = wb_result;
        end else if (mByp) begin
            eWe = 1; eRd = ll_rd; eWd = ll_result;
        end
        mEnq = ll_valid && eReady && (ll_rd != 0) && !mByp;
    endtask

    task automatic modelCommit();
        bit wasEmpty;
        wasEmpty = (mq.size() == 0);
        if (mPop || mByp) mBusy[eRd] = 1'b0;
        if (ll_issue_valid && ll_issue_rd != 0) mBusy[ll_issue_rd] = 1'b1;
        mBusy[0] = 1'b0;
        if (mPop) void'(mq.pop_front());
        if (mEnq) mq.push_back('{rd: ll_rd, data: ll_result});
        mAge = (mPop || wasEmpty) ? 0 : mAge + 1;
    endtask

    typedef struct {
        logic        wbWe;  logic [4:0] wbRd;  logic [31:0] wbRes;
        logic        issV;  logic [4:0] issRd;
        logic        llV;   logic [4:0] llRd;  logic [31:0] llRes;
        logic        expWe; logic [4:0] expRd; logic [31:0] expWd;
        logic [31:0] expBusy; logic [CW-1:0] expCount;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Single-cycle directed vectors applied back to back after reset.
        vecs[0] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd0, 32'h0, 32'h0, CW'(0)};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF,
                    BYP, 5'd5, 32'hDEAD_BEEF, 32'h20, CW'(0)};
        vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    !BYP, 5'd5, 32'hDEAD_BEEF, BYP ? 32'h0 : 32'h20, BYP ? CW'(0) : CW'(1)};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd0, 32'h0, 32'h0, CW'(0)};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1234,
                    1'b0, 5'd0, 32'h0, 32'h0, CW'(0)};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd0, 32'h0, 32'h0, CW'(0)};
        vecs[6] = '{1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd3, 32'hAAAA, 32'h0, CW'(0)};
        vecs[7] = '{1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd0, 32'h0, 32'h0, CW'(0)};

        step();
        @(negedge clk);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_stall", 32'(stall_wb), 0);
        chk("rst_ready", 32'(ll_ready), 1);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_busy", pending_busy, 0);
        doReset();

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wbWe, vecs[i].wbRd, vecs[i].wbRes, vecs[i].issV, vecs[i].issRd,
                  vecs[i].llV, vecs[i].llRd, vecs[i].llRes);
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].expWe));
            if (vecs[i].expWe) begin
                chk($sformatf("vec%0d_rd", i), 32'(rf_rd), 32'(vecs[i].expRd));
                chk($sformatf("vec%0d_wd", i), rf_wd, vecs[i].expWd);
            end
            chk($sformatf("vec%0d_busy", i), pending_busy, vecs[i].expBusy);
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].expCount));
            step();
        end

        // Aging: x7 waits behind continuous x3 writes until forced stall.
        doReset();
        drive(1, 3, 32'h33, 1, 7, 1, 7, 32'h7777);
        step();
        drive(1, 3, 32'h33, 0, 0, 0, 0, 0);
        for (int k = 0; k < MAX_WAIT; k++) begin
            @(negedge clk);
            chk($sformatf("age_c%0d_stall", k), 32'(stall_wb), 0);
            chk($sformatf("age_c%0d_rd", k), 32'(rf_rd), 3);
            step();
        end
        @(negedge clk);
        chk("age_stall", 32'(stall_wb), 1);
        chk("age_rd7", 32'(rf_rd), 7);
        chk("age_wd7", rf_wd, 32'h7777);
        step();
        @(negedge clk);
        chk("age_after_stall", 32'(stall_wb), 0);
        chk("age_after_rd3", 32'(rf_rd), 3);
        chk("age_after_busy7", 32'(pending_busy[7]), 0);
        chk("age_after_count", 32'(fifo_count), 0);
        step();

        // Full FIFO backpressure with a fifth result held.
        doReset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 32'h33, 0, 0, 1, 5'(10 + i), 32'(100 + i));
            @(negedge clk);
            chk($sformatf("fill%0d_ready", i), 32'(ll_ready), 1);
            step();
        end
        drive(1, 3, 32'h33, 0, 0, 1, 5'd14, 32'd104);
        begin
            bit seen;
            seen = 0;
            @(negedge clk);
            chk("full_ready", 32'(ll_ready), 0);
            chk("full_count", 32'(fifo_count), 4);
            for (int k = 0; k < 20 && !seen; k++) begin
                if (stall_wb) seen = 1;
                else begin step(); @(negedge clk); end
            end
            chk("full_stall_seen", 32'(seen), 1);
        end
        chk("full_stall_rd", 32'(rf_rd), 10);
        chk("full_stall_ready", 32'(ll_ready), 0);
        step();
        @(negedge clk);
        chk("full_drained_ready", 32'(ll_ready), 1);
        chk("full_drained_count", 32'(fifo_count), 3);
        step();
        drive(1, 3, 32'h33, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_refill_count", 32'(fifo_count), 4);

        // Re-issue to x9 in the same cycle its previous result commits.
        doReset();
        drive(0, 0, 0, 1, 9, 0, 0, 0);
        step();
        drive(1, 3, 32'h33, 0, 0, 1, 9, 32'h9999);
        step();
        drive(0, 0, 0, 1, 9, 0, 0, 0);
        @(negedge clk);
        chk("reiss_we", 32'(rf_we), 1);
        chk("reiss_rd", 32'(rf_rd), 9);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reiss_busy9", 32'(pending_busy[9]), 1);
        chk("reiss_count", 32'(fifo_count), 0);

        // Asynchronous reset with three entries queued.
        doReset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 32'h33, 1, 5'(20 + i), 1, 5'(20 + i), 32'(200 + i));
            step();
        end
        drive(1, 3, 32'h33, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("arst_pre_count", 32'(fifo_count), 3);
        chk("arst_pre_busy", pending_busy, 32'h0070_0000);
        #1 reset = 1'b1;
        #1;
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_busy", pending_busy, 0);
        chk("arst_we", 32'(rf_we), 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("arst_resume_we", 32'(rf_we), 1);
        chk("arst_resume_rd", 32'(rf_rd), 3);
        chk("arst_resume_count", 32'(fifo_count), 0);

        // Randomized traffic against the reference model.
        doReset();
        mq.delete();
        mAge = 0;
        mBusy = '0;
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom);
            modelEval();
            @(negedge clk);
            chk("rnd_we", 32'(rf_we), 32'(eWe));
            if (eWe) begin
                chk("rnd_rd", 32'(rf_rd), 32'(eRd));
                chk("rnd_wd", rf_wd, eWd);
            end
            chk("rnd_stall", 32'(stall_wb), 32'(eStall));
            chk("rnd_ready", 32'(ll_ready), 32'(eReady));
            chk("rnd_count", 32'(fifo_count), 32'(mq.size()));
            chk("rnd_busy", pending_busy, mBusy);
            step();
            modelCommit();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
